// File: rtl/game_sequencer.sv
// Game-phase controller: sequences idle/ready/play/death/win/over, owns the lives
// counter and derives per-sprite move enables from the common game tick.
module game_sequencer #(
    parameter int LIVES       = 3,
    parameter int READY_TICKS = 32,
    parameter int DEATH_TICKS = 48,
    parameter int PAC_DIV     = 4,
    parameter int GHOST_DIV   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       collide,
    input  logic       food_clear,
    output logic       pac_move_en,
    output logic       ghost_move_en,
    output logic       respawn,
    output logic       food_reload,
    output logic       freeze,
    output logic [2:0] lives,
    output logic [2:0] state,
    output logic       gamewin,
    output logic       gamelose
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READY = 3'd1,
        S_PLAY  = 3'd2,
        S_DYING = 3'd3,
        S_WIN   = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    localparam int CNT_MAX = (READY_TICKS > DEATH_TICKS) ? READY_TICKS : DEATH_TICKS;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int PW      = $clog2(PAC_DIV + 1);
    localparam int GW      = $clog2(GHOST_DIV + 1);

    localparam logic [CW-1:0] READY_LAST = CW'(READY_TICKS - 1);
    localparam logic [CW-1:0] DEATH_LAST = CW'(DEATH_TICKS - 1);
    localparam logic [CW-1:0] CNT_SAT    = CW'(CNT_MAX);
    localparam logic [PW-1:0] PAC_LAST   = PW'(PAC_DIV - 1);
    localparam logic [GW-1:0] GHOST_LAST = GW'(GHOST_DIV - 1);
    localparam logic [2:0]    LIVES_INIT = 3'(LIVES);

    state_t        state_q, state_d;
    logic [2:0]    lives_q, lives_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pac_div_q, pac_div_d;
    logic [GW-1:0] ghost_div_q, ghost_div_d;
    logic          start_q, start_d;
    logic          pac_en_q, pac_en_d;
    logic          ghost_en_q, ghost_en_d;
    logic          respawn_q, respawn_d;
    logic          reload_q, reload_d;
    logic          freeze_q, freeze_d;
    logic          gamewin_q, gamewin_d;
    logic          gamelose_q, gamelose_d;
    logic          start_rise;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_SAT) ? v : v + CW'(1);
    endfunction

    assign start_rise = start & ~start_q;

    // Next-state, counter and pulse decode; outputs are derived from the next state so they register with it.
    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        cnt_d       = cnt_q;
        pac_div_d   = pac_div_q;
        ghost_div_d = ghost_div_q;
        start_d     = start;
        pac_en_d    = 1'b0;
        ghost_en_d  = 1'b0;
        respawn_d   = 1'b0;
        reload_d    = 1'b0;
        case (state_q)
            S_IDLE, S_WIN, S_OVER: begin
                if (start_rise) begin
                    state_d   = S_READY;
                    respawn_d = 1'b1;
                    reload_d  = 1'b1;
                    lives_d   = LIVES_INIT;
                    cnt_d     = {CW{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            S_READY: begin
                if (tick) begin
                    if (cnt_q == READY_LAST) begin
                        state_d     = S_PLAY;
                        cnt_d       = {CW{1'b0}};
                        pac_div_d   = {PW{1'b0}};
                        ghost_div_d = {GW{1'b0}};
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_PLAY: begin
                // Exits take priority over movement so no enable fires on the way out.
                if (food_clear) begin
                    state_d = S_WIN;
                end else if (collide) begin
                    state_d = S_DYING;
                    lives_d = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
                    cnt_d   = {CW{1'b0}};
                end else if (tick) begin
                    if (pac_div_q == PAC_LAST) begin
                        pac_div_d = {PW{1'b0}};
                        pac_en_d  = 1'b1;
                    end else begin
                        pac_div_d = pac_div_q + PW'(1);
                    end
                    if (ghost_div_q == GHOST_LAST) begin
                        ghost_div_d = {GW{1'b0}};
                        ghost_en_d  = 1'b1;
                    end else begin
                        ghost_div_d = ghost_div_q + GW'(1);
                    end
                end else begin
                    state_d = S_PLAY;
                end
            end
            S_DYING: begin
                if (tick) begin
                    if (cnt_q == DEATH_LAST) begin
                        cnt_d = {CW{1'b0}};
                        if (lives_q == 3'd0) begin
                            state_d = S_OVER;
                        end else begin
                            state_d   = S_READY;
                            respawn_d = 1'b1;
                        end
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
        freeze_d   = (state_d != S_PLAY);
        gamewin_d  = (state_d == S_WIN);
        gamelose_d = (state_d == S_OVER);
    end

    // State and registered-output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            lives_q     <= LIVES_INIT;
            cnt_q       <= {CW{1'b0}};
            pac_div_q   <= {PW{1'b0}};
            ghost_div_q <= {GW{1'b0}};
            start_q     <= 1'b1;
            pac_en_q    <= 1'b0;
            ghost_en_q  <= 1'b0;
            respawn_q   <= 1'b0;
            reload_q    <= 1'b0;
            freeze_q    <= 1'b1;
            gamewin_q   <= 1'b0;
            gamelose_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            cnt_q       <= cnt_d;
            pac_div_q   <= pac_div_d;
            ghost_div_q <= ghost_div_d;
            start_q     <= start_d;
            pac_en_q    <= pac_en_d;
            ghost_en_q  <= ghost_en_d;
            respawn_q   <= respawn_d;
            reload_q    <= reload_d;
            freeze_q    <= freeze_d;
            gamewin_q   <= gamewin_d;
            gamelose_q  <= gamelose_d;
        end
    end

    assign state         = state_q;
    assign lives         = lives_q;
    assign pac_move_en   = pac_en_q;
    assign ghost_move_en = ghost_en_q;
    assign respawn       = respawn_q;
    assign food_reload   = reload_q;
    assign freeze        = freeze_q;
    assign gamewin       = gamewin_q;
    assign gamelose      = gamelose_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: a phase-level reference model predicts every
// cycle's outputs into a queue, and a negedge monitor pops and compares them.
module tb_game_sequencer;

    localparam int LIVES       = 3;
    localparam int READY_TICKS = 32;
    localparam int DEATH_TICKS = 48;
    localparam int PAC_DIV     = 4;
    localparam int GHOST_DIV   = 5;

    logic       clk = 1'b0;
    logic       reset, tick, start, collide, food_clear;
    logic       pac_move_en, ghost_move_en, respawn, food_reload, freeze;
    logic [2:0] lives, state;
    logic       gamewin, gamelose;

    always #5 clk = ~clk;

    game_sequencer #(
        .LIVES(LIVES), .READY_TICKS(READY_TICKS), .DEATH_TICKS(DEATH_TICKS),
        .PAC_DIV(PAC_DIV), .GHOST_DIV(GHOST_DIV)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .collide(collide),
        .food_clear(food_clear), .pac_move_en(pac_move_en), .ghost_move_en(ghost_move_en),
        .respawn(respawn), .food_reload(food_reload), .freeze(freeze), .lives(lives),
        .state(state), .gamewin(gamewin), .gamelose(gamelose)
    );

    typedef struct packed {
        logic [2:0] st;
        logic [2:0] lv;
        logic       frz, win, lose, pac, ghost, resp, rel;
    } obs_t;

    obs_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: phase number, lives, ticks seen in current phase.
    int m_phase, m_lives, m_cnt, m_play_ticks;
    bit m_start_prev, m_pac, m_ghost, m_resp, m_rel;
    bit st_lvl;

    task automatic new_game();
        m_phase = 1; m_resp = 1'b1; m_rel = 1'b1; m_lives = LIVES; m_cnt = 0;
    endtask

    task automatic model_step(input bit r, input bit t, input bit s, input bit c, input bit f);
        bit rise;
        m_pac = 1'b0; m_ghost = 1'b0; m_resp = 1'b0; m_rel = 1'b0;
        if (r) begin
            m_phase = 0; m_lives = LIVES; m_cnt = 0; m_play_ticks = 0; m_start_prev = 1'b1;
        end else begin
            rise = s && !m_start_prev;
            m_start_prev = s;
            case (m_phase)
                0, 4, 5: if (rise) new_game();
                1: if (t) begin
                    m_cnt++;
                    if (m_cnt == READY_TICKS) begin
                        m_phase = 2; m_cnt = 0; m_play_ticks = 0;
                    end
                end
                2: begin
                    if (f) m_phase = 4;
                    else if (c) begin
                        m_phase = 3; m_cnt = 0;
                        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                    end else if (t) begin
                        m_play_ticks++;
                        m_pac   = (m_play_ticks % PAC_DIV) == 0;
                        m_ghost = (m_play_ticks % GHOST_DIV) == 0;
                    end
                end
                3: if (t) begin
                    m_cnt++;
                    if (m_cnt == DEATH_TICKS) begin
                        m_cnt = 0;
                        if (m_lives == 0) m_phase = 5;
                        else begin m_phase = 1; m_resp = 1'b1; end
                    end
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic cycle(input bit r, input bit t, input bit s, input bit c, input bit f);
        obs_t e;
        reset = r; tick = t; start = s; collide = c; food_clear = f;
        model_step(r, t, s, c, f);
        e.st = 3'(m_phase); e.lv = 3'(m_lives);
        e.frz = (m_phase != 2); e.win = (m_phase == 4); e.lose = (m_phase == 5);
        e.pac = m_pac; e.ghost = m_ghost; e.resp = m_resp; e.rel = m_rel;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Drive toward a target phase: start edges where needed, random ticks, collide/food_clear in play.
    task automatic advance_to(input int ph, input int limit);
        int n = 0;
        while (m_phase != ph && n < limit) begin
            if (m_phase == 0 || m_phase == 4 || m_phase == 5) begin
                st_lvl = ~st_lvl;
                cycle(1'b0, 1'($urandom_range(0, 1)), st_lvl, 1'b0, 1'b0);
            end else if (m_phase == 2) begin
                cycle(1'b0, 1'($urandom_range(0, 1)), st_lvl, (ph == 3 || ph == 5), (ph == 4));
            end else begin
                cycle(1'b0, 1'($urandom_range(0, 1)), st_lvl, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
            end
            n++;
        end
        if (m_phase != ph) begin
            errors++;
            $display("FAIL advance_to phase got %0d required %0d within %0d cycles", m_phase, ph, limit);
        end
    endtask

    // Monitor: the DUT presents a full output snapshot every cycle.
    always @(negedge clk) begin
        obs_t a, e;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {state, lives, freeze, gamewin, gamelose, pac_move_en, ghost_move_en, respawn, food_reload};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t got st=%0d lv=%0d frz=%b win=%b lose=%b pac=%b gh=%b resp=%b rel=%b required st=%0d lv=%0d frz=%b win=%b lose=%b pac=%b gh=%b resp=%b rel=%b",
                         $time, a.st, a.lv, a.frz, a.win, a.lose, a.pac, a.ghost, a.resp, a.rel,
                         e.st, e.lv, e.frz, e.win, e.lose, e.pac, e.ghost, e.resp, e.rel);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        st_lvl = 1'b1;
        repeat (3) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        advance_to(2, 200);
        for (int i = 0; i < 40; i++)
            cycle(1'b0, (i % 2) == 0, (i == 5) ? 1'b0 : 1'b1, 1'b0, 1'b0);

        advance_to(5, 3000);
        advance_to(2, 300);
        cycle(1'b0, 1'b1, st_lvl, 1'b1, 1'b1);
        repeat (3) cycle(1'b0, 1'b1, st_lvl, 1'b1, 1'b0);

        advance_to(3, 400);
        repeat (5) cycle(1'b0, 1'b1, st_lvl, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, st_lvl, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 1'b1, st_lvl, 1'b0, 1'b0);

        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 19) == 0) st_lvl = ~st_lvl;
            cycle($urandom_range(0, 999) == 0, 1'($urandom_range(0, 1)), st_lvl,
                  $urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0);
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
